// File: rtl/jk_count_seq.sv
`default_nettype none
// ============================================================================
// Module   : jk_count_seq
// Purpose  : j/k excitation sequencer that runs an external JK-flop bank as a
//            loadable up/down counter stopping at a terminal value.
//            Optional q_fb-vs-shadow comparator: JK_SEQ_CHECK_EN.
// Revision : 1.0
// ============================================================================
module jk_count_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ack,
  input  logic             start,
  input  logic             up_dn,
  input  logic             halt,
  input  logic [WIDTH-1:0] term_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] w_exp_nxt;
  logic [WIDTH-1:0] w_toggle;
  logic             r_done;
  logic             w_done_nxt;

  // Reset forces INIT behaviour in the same cycle so the bank clears at the edge.
  assign w_state = rst_n ? r_state : S_INIT;

  // Bits that change between exp and its neighbour are exactly the toggling flops.
  assign w_toggle = up_dn ? (r_exp ^ (r_exp + c_ONE)) : (r_exp ^ (r_exp - c_ONE));

  always_comb begin
    w_state_nxt = w_state;
    w_exp_nxt   = r_exp;
    w_done_nxt  = 1'b0;
    j           = '0;
    k           = '0;
    load_ack    = 1'b0;
    busy        = 1'b1;
    case (w_state)
      S_INIT: begin
        k           = '1;
        w_exp_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        if (load_req) begin
          w_state_nxt = S_LOAD;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_LOAD: begin
        j           = load_val;
        k           = ~load_val;
        load_ack    = 1'b1;
        w_exp_nxt   = load_val;
        w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (halt) begin
          w_state_nxt = S_IDLE;
        end else if (r_exp == term_val) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          j         = w_toggle;
          k         = w_toggle;
          w_exp_nxt = up_dn ? (r_exp + c_ONE) : (r_exp - c_ONE);
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_exp   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign done = r_done & rst_n;

`ifdef JK_SEQ_CHECK_EN
  logic r_mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
    end else if ((r_state != S_INIT) && (q_fb != r_exp)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch & rst_n;
`else
  logic w_unused_qfb;
  assign w_unused_qfb = ^q_fb;
  assign mismatch     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_count_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_count_seq
// Purpose  : vector table + scoreboard bench for jk_count_seq with a 4-flop JK bank.
// Revision : 1.0
// ============================================================================
module tb_jk_count_seq;

`ifdef JK_SEQ_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    bit         rst;
    bit         lreq;
    logic [3:0] lval;
    bit         st;
    bit         up;
    bit         hl;
    logic [3:0] term;
    logic [3:0] flip;
    logic [3:0] ej;
    logic [3:0] ek;
    bit         eack;
    bit         ebusy;
    bit         edone;
    logic [3:0] eq;
    bit         emm;
    int         tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_req = 1'b0;
  logic [3:0] load_val = '0;
  logic       load_ack;
  logic       start = 1'b0;
  logic       up_dn = 1'b0;
  logic       halt = 1'b0;
  logic [3:0] term_val = '0;
  logic [3:0] q_fb;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;
  logic       mismatch;

  logic [3:0] bank_q = 4'h6;
  logic [3:0] flip = '0;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  jk_count_seq #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_req (load_req),
    .load_val (load_val),
    .load_ack (load_ack),
    .start    (start),
    .up_dn    (up_dn),
    .halt     (halt),
    .term_val (term_val),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank; flip corrupts the feedback path only.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end
  assign q_fb = bank_q ^ flip;

  function automatic vec_t mk(bit rst, bit lreq, logic [3:0] lval, bit st, bit up, bit hl,
                              logic [3:0] term, logic [3:0] fl, logic [3:0] ej, logic [3:0] ek,
                              bit eack, bit ebusy, bit edone, logic [3:0] eq, bit emm);
    vec_t v;
    v.rst = rst; v.lreq = lreq; v.lval = lval; v.st = st; v.up = up; v.hl = hl;
    v.term = term; v.flip = fl; v.ej = ej; v.ek = ek; v.eack = eack; v.ebusy = ebusy;
    v.edone = edone; v.eq = eq; v.emm = emm; v.tag = 0;
    return v;
  endfunction

  task automatic chk(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int tag);
    vec_t e;
    @(posedge clk);
    #1;
    rst_n    = v.rst;
    load_req = v.lreq;
    load_val = v.lval;
    start    = v.st;
    up_dn    = v.up;
    halt     = v.hl;
    term_val = v.term;
    flip     = v.flip;
    e        = v;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  // Outputs are sampled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("j",        e.tag, j,                 e.ej);
      chk("k",        e.tag, k,                 e.ek);
      chk("load_ack", e.tag, {3'b0, load_ack},  {3'b0, e.eack});
      chk("busy",     e.tag, {3'b0, busy},      {3'b0, e.ebusy});
      chk("done",     e.tag, {3'b0, done},      {3'b0, e.edone});
      chk("q_fb",     e.tag, q_fb,              e.eq);
      chk("mismatch", e.tag, {3'b0, mismatch},  {3'b0, e.emm});
    end
  end

  initial begin
    logic [3:0] q;
    // rst lreq lval st up hl term flip | j k ack busy done q mm
    tbl.push_back(mk(0,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(0,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(0,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h0,0));
    tbl.push_back(mk(1,1,4'hA,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h0,0));
    tbl.push_back(mk(1,0,4'hA,0,0,0,4'h0,4'h0, 4'hA,4'h5,1,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'hA,0));
    tbl.push_back(mk(1,1,4'hD,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'hA,0));
    tbl.push_back(mk(1,0,4'hD,0,0,0,4'h0,4'h0, 4'hD,4'h2,1,1,0,4'hA,0));
    tbl.push_back(mk(1,0,4'h0,1,1,0,4'h2,4'h0, 4'h0,4'h0,0,0,0,4'hD,0));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'h3,4'h3,0,1,0,4'hD,0));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'h1,4'h1,0,1,0,4'hE,0));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'hF,4'hF,0,1,0,4'hF,0));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'h1,4'h1,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'h3,4'h3,0,1,0,4'h1,0));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'h0,4'h0,0,1,0,4'h2,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,1,4'h2,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h2,0));
    tbl.push_back(mk(1,1,4'h3,1,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h2,0));
    tbl.push_back(mk(1,0,4'h3,1,0,0,4'h0,4'h0, 4'h3,4'hC,1,1,0,4'h2,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h3,0));
    tbl.push_back(mk(1,0,4'h0,1,0,0,4'hE,4'h0, 4'h0,4'h0,0,0,0,4'h3,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h0, 4'h1,4'h1,0,1,0,4'h3,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h0, 4'h3,4'h3,0,1,0,4'h2,0));
    tbl.push_back(mk(1,0,4'h0,0,0,1,4'hE,4'h0, 4'h0,4'h0,0,1,0,4'h1,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h1,0));
    tbl.push_back(mk(1,0,4'h0,1,0,0,4'hE,4'h0, 4'h0,4'h0,0,0,0,4'h1,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h0, 4'h1,4'h1,0,1,0,4'h1,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h0, 4'hF,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h4, 4'h1,4'h1,0,1,0,4'hB,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h0, 4'h0,4'h0,0,1,0,4'hE,CK));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,1,4'hE,CK));
    tbl.push_back(mk(1,0,4'h0,1,0,0,4'hE,4'h0, 4'h0,4'h0,0,0,0,4'hE,CK));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'hE,4'h0, 4'h0,4'h0,0,1,0,4'hE,CK));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,1,4'hE,CK));
    tbl.push_back(mk(1,0,4'h0,1,1,0,4'h2,4'h0, 4'h0,4'h0,0,0,0,4'hE,CK));
    tbl.push_back(mk(1,0,4'h0,0,1,0,4'h2,4'h0, 4'h1,4'h1,0,1,0,4'hE,CK));
    tbl.push_back(mk(0,0,4'h0,0,1,0,4'h2,4'h0, 4'h0,4'hF,0,1,0,4'hF,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h0,0));
    tbl.push_back(mk(1,1,4'h7,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h0,0));
    tbl.push_back(mk(0,0,4'h7,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'hF,0,1,0,4'h0,0));
    tbl.push_back(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h0,0));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], i);

    // Full up-count lap from 5 through the wrap to terminal 4.
    drive(mk(1,1,4'h5,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,0,4'h0,0), 100);
    drive(mk(1,0,4'h5,0,0,0,4'h0,4'h0, 4'h5,4'hA,1,1,0,4'h0,0), 101);
    drive(mk(1,0,4'h0,1,1,0,4'h4,4'h0, 4'h0,4'h0,0,0,0,4'h5,0), 102);
    q = 4'h5;
    for (int s = 0; s < 15; s++) begin
      drive(mk(1,0,4'h0,0,1,0,4'h4,4'h0, q ^ (q + 4'h1), q ^ (q + 4'h1),0,1,0,q,0), 110 + s);
      q = q + 4'h1;
    end
    drive(mk(1,0,4'h0,0,1,0,4'h4,4'h0, 4'h0,4'h0,0,1,0,4'h4,0), 130);
    drive(mk(1,0,4'h0,0,0,0,4'h0,4'h0, 4'h0,4'h0,0,0,1,4'h4,0), 131);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
